// File: rtl/button_event_arbiter_if.sv
// rtl/button_event_arbiter_if.sv - event stream handshake between arbiter and consumer
interface button_event_arbiter_if;
   logic       ev_valid;
   logic       ev_ready;
   logic [1:0] ev_code;
   logic       ev_rpt;

   modport master (output ev_valid, output ev_code, output ev_rpt, input ev_ready);
   modport slave  (input ev_valid, input ev_code, input ev_rpt, output ev_ready);
endinterface

// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - four-button press/auto-repeat event generator with round-robin output
module button_event_arbiter #(
   parameter int HOLD_CYC   = 1000,
   parameter int REPEAT_CYC = 250
) (
   input  logic                          clk,
   input  logic                          n_reset,
   input  logic [3:0]                    db_in,
   input  logic                          rpt_en,
   button_event_arbiter_if.master        ev,
   output logic [3:0]                    ovr,
   input  logic                          ovr_clr
);

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

   localparam logic [15:0] HOLD_TERM   = 16'(HOLD_CYC - 1);
   localparam logic [15:0] REPEAT_TERM = 16'(REPEAT_CYC - 1);

   state_t      state_q [4];
   state_t      state_d [4];
   logic [15:0] cnt_q   [4];
   logic [15:0] cnt_d   [4];

   logic [3:0] db_prev_q, pend_q, pend_d, pend_rpt_q, pend_rpt_d, ovr_q, ovr_d;
   logic [3:0] ev_hit, ev_typ, grant;
   logic       ev_valid_q, ev_valid_d, ev_rpt_q, ev_rpt_d;
   logic [1:0] ev_code_q, ev_code_d, rr_ptr_q, rr_ptr_d, gidx, cand;
   logic       load, gfound;

   // Release wins over everything; a held counter sits at its terminal value while rpt_en=0.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         ev_hit[i]  = 1'b0;
         ev_typ[i]  = 1'b0;
         if (!db_in[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
         end else begin
            case (state_q[i])
               IDLE: begin
                  if (!db_prev_q[i]) begin
                     state_d[i] = HOLD;
                     cnt_d[i]   = '0;
                     ev_hit[i]  = 1'b1;
                  end
               end
               HOLD: begin
                  if (cnt_q[i] == HOLD_TERM) begin
                     if (rpt_en) begin
                        state_d[i] = REPEAT;
                        cnt_d[i]   = '0;
                        ev_hit[i]  = 1'b1;
                        ev_typ[i]  = 1'b1;
                     end
                  end else begin
                     cnt_d[i] = cnt_q[i] + 16'd1;
                  end
               end
               REPEAT: begin
                  if (cnt_q[i] == REPEAT_TERM) begin
                     if (rpt_en) begin
                        cnt_d[i]  = '0;
                        ev_hit[i] = 1'b1;
                        ev_typ[i] = 1'b1;
                     end
                  end else begin
                     cnt_d[i] = cnt_q[i] + 16'd1;
                  end
               end
               default: begin
                  state_d[i] = IDLE;
                  cnt_d[i]   = '0;
               end
            endcase
         end
      end
   end

   // Round-robin pick from rr_ptr upward; a new event for the granted button stays pending.
   always_comb begin
      load   = !ev_valid_q || ev.ev_ready;
      gfound = 1'b0;
      gidx   = rr_ptr_q;
      cand   = rr_ptr_q;
      grant  = '0;
      for (int k = 0; k < 4; k++) begin
         cand = rr_ptr_q + 2'(k);
         if (!gfound && pend_q[cand]) begin
            gfound = 1'b1;
            gidx   = cand;
         end
      end
      if (load && gfound) grant[gidx] = 1'b1;

      pend_d     = (pend_q & ~grant) | ev_hit;
      pend_rpt_d = (pend_rpt_q & ~ev_hit) | (ev_typ & ev_hit);
      ovr_d      = (ovr_clr ? 4'b0000 : ovr_q) | (ev_hit & pend_q & ~grant);

      ev_valid_d = ev_valid_q;
      ev_code_d  = ev_code_q;
      ev_rpt_d   = ev_rpt_q;
      rr_ptr_d   = rr_ptr_q;
      if (load) begin
         ev_valid_d = gfound;
         if (gfound) begin
            ev_code_d = gidx;
            ev_rpt_d  = pend_rpt_q[gidx];
            rr_ptr_d  = gidx + 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
         end
         db_prev_q  <= '0;
         pend_q     <= '0;
         pend_rpt_q <= '0;
         ovr_q      <= '0;
         ev_valid_q <= 1'b0;
         ev_code_q  <= '0;
         ev_rpt_q   <= 1'b0;
         rr_ptr_q   <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         db_prev_q  <= db_in;
         pend_q     <= pend_d;
         pend_rpt_q <= pend_rpt_d;
         ovr_q      <= ovr_d;
         ev_valid_q <= ev_valid_d;
         ev_code_q  <= ev_code_d;
         ev_rpt_q   <= ev_rpt_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   assign ev.ev_valid = ev_valid_q;
   assign ev.ev_code  = ev_code_q;
   assign ev.ev_rpt   = ev_rpt_q;
   assign ovr         = ovr_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// tb/tb_button_event_arbiter.sv - self-checking bench for button_event_arbiter
module tb_button_event_arbiter;

   logic       clk = 1'b0;
   logic       n_reset;
   logic [3:0] db_a, db_b, ovr_a, ovr_b;
   logic       rpt_a, rpt_b, clr_a, clr_b;

   button_event_arbiter_if a_if ();
   button_event_arbiter_if b_if ();

   button_event_arbiter #(.HOLD_CYC(8), .REPEAT_CYC(4)) dut_a (
      .clk(clk), .n_reset(n_reset), .db_in(db_a), .rpt_en(rpt_a),
      .ev(a_if), .ovr(ovr_a), .ovr_clr(clr_a)
   );

   button_event_arbiter #(.HOLD_CYC(2), .REPEAT_CYC(2)) dut_b (
      .clk(clk), .n_reset(n_reset), .db_in(db_b), .rpt_en(rpt_b),
      .ev(b_if), .ovr(ovr_b), .ovr_clr(clr_b)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [3:0] db;
      logic       rdy;
      logic       clr;
      logic       push;
      logic [1:0] pcode;
      logic       v;
      logic [1:0] c;
      logic [3:0] o;
   } vec_t;

   vec_t       tbl [$];
   logic [2:0] sb_q [$];
   int         tests = 0;
   int         fails = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Scoreboard pop happens here, with inputs settled and outputs stable before the edge.
   task automatic step();
      logic [2:0] exp;
      if (n_reset && a_if.ev_valid && a_if.ev_ready) begin
         if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_unexpected: got code %0d rpt %0d, required no event",
                     a_if.ev_code, a_if.ev_rpt);
         end else begin
            exp = sb_q.pop_front();
            chk("sb_event", {5'd0, a_if.ev_code, a_if.ev_rpt}, {5'd0, exp});
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      n_reset = 1'b0;
      db_a    = '0;
      db_b    = '0;
      step();
      n_reset = 1'b1;
   endtask

   task automatic add(input logic rst, input logic [3:0] db, input logic rdy, input logic clr,
                      input logic push, input logic [1:0] pcode,
                      input logic v, input logic [1:0] c, input logic [3:0] o);
      vec_t t;
      t.rst = rst; t.db = db; t.rdy = rdy; t.clr = clr; t.push = push; t.pcode = pcode;
      t.v = v; t.c = c; t.o = o;
      tbl.push_back(t);
   endtask

   initial begin
      int n3, c0;
      n_reset = 1'b0;
      db_a = '0; db_b = '0; rpt_a = 1'b0; rpt_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
      a_if.ev_ready = 1'b0;
      b_if.ev_ready = 1'b0;
      step();
      step();

      // reset state
      add(0, 4'b0000, 1, 1, 0, 0, 0, 0, 4'b0000);
      // single press, ready high
      add(1, 4'b0001, 1, 0, 1, 0, 0, 0, 4'b0000);
      add(1, 4'b0001, 1, 0, 0, 0, 1, 0, 4'b0000);
      for (int i = 0; i < 8; i++) add(1, 4'b0001, 1, 0, 0, 0, 0, 0, 4'b0000);
      add(1, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0000);
      add(1, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0000);
      // backpressure and overrun, then overrun coinciding with ovr_clr
      add(0, 4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000);
      add(1, 4'b0010, 0, 0, 1, 1, 0, 0, 4'b0000);
      add(1, 4'b0010, 0, 0, 0, 0, 1, 1, 4'b0000);
      add(1, 4'b0000, 0, 0, 0, 0, 1, 1, 4'b0000);
      add(1, 4'b0010, 0, 0, 1, 1, 1, 1, 4'b0000);
      add(1, 4'b0000, 0, 0, 0, 0, 1, 1, 4'b0000);
      add(1, 4'b0010, 0, 0, 0, 0, 1, 1, 4'b0010);
      add(1, 4'b0000, 0, 0, 0, 0, 1, 1, 4'b0010);
      add(1, 4'b0000, 1, 0, 0, 0, 1, 1, 4'b0010);
      add(1, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0010);
      add(1, 4'b0000, 1, 1, 0, 0, 0, 0, 4'b0000);
      add(1, 4'b0010, 0, 0, 1, 1, 0, 0, 4'b0000);
      add(1, 4'b0000, 0, 0, 0, 0, 1, 1, 4'b0000);
      add(1, 4'b0010, 0, 0, 1, 1, 1, 1, 4'b0000);
      add(1, 4'b0000, 0, 0, 0, 0, 1, 1, 4'b0000);
      add(1, 4'b0010, 0, 1, 0, 0, 1, 1, 4'b0010);
      add(1, 4'b0000, 1, 0, 0, 0, 1, 1, 4'b0010);
      add(1, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0010);
      add(1, 4'b0000, 0, 1, 0, 0, 0, 0, 4'b0000);
      // new event on the edge its pending bit is granted
      add(0, 4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000);
      add(1, 4'b0001, 0, 0, 1, 0, 0, 0, 4'b0000);
      add(1, 4'b0001, 0, 0, 0, 0, 1, 0, 4'b0000);
      add(1, 4'b0000, 0, 0, 0, 0, 1, 0, 4'b0000);
      add(1, 4'b0001, 0, 0, 1, 0, 1, 0, 4'b0000);
      add(1, 4'b0000, 0, 0, 0, 0, 1, 0, 4'b0000);
      add(1, 4'b0001, 1, 0, 1, 0, 1, 0, 4'b0000);
      add(1, 4'b0000, 1, 0, 0, 0, 1, 0, 4'b0000);
      add(1, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0000);
      // reset mid-operation, button 0 held across the reset
      add(0, 4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000);
      add(1, 4'b0110, 0, 0, 0, 0, 0, 0, 4'b0000);
      add(1, 4'b0110, 0, 0, 0, 0, 1, 1, 4'b0000);
      add(1, 4'b0111, 0, 0, 0, 0, 1, 1, 4'b0000);
      add(0, 4'b0001, 1, 1, 0, 0, 0, 0, 4'b0000);
      add(1, 4'b0001, 1, 0, 1, 0, 0, 0, 4'b0000);
      add(1, 4'b0001, 1, 0, 0, 0, 1, 0, 4'b0000);
      add(1, 4'b0001, 1, 0, 0, 0, 0, 0, 4'b0000);
      for (int i = 0; i < 3; i++) add(1, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0000);

      foreach (tbl[i]) begin
         n_reset       = tbl[i].rst;
         db_a          = tbl[i].db;
         a_if.ev_ready = tbl[i].rdy;
         clr_a         = tbl[i].clr;
         if (tbl[i].push) sb_q.push_back({tbl[i].pcode, 1'b0});
         step();
         chk($sformatf("tbl%0d_valid", i), {7'd0, a_if.ev_valid}, {7'd0, tbl[i].v});
         chk($sformatf("tbl%0d_ovr", i), {4'd0, ovr_a}, {4'd0, tbl[i].o});
         if (tbl[i].v || !tbl[i].rst) begin
            chk($sformatf("tbl%0d_code", i), {6'd0, a_if.ev_code}, {6'd0, tbl[i].c});
            chk($sformatf("tbl%0d_rpt", i), {7'd0, a_if.ev_rpt}, 8'd0);
         end
      end
      n_reset = 1'b1;
      clr_a   = 1'b0;

      // simultaneous press of all four buttons
      do_reset();
      a_if.ev_ready = 1'b1;
      for (int i = 0; i < 4; i++) sb_q.push_back({2'(i), 1'b0});
      db_a = 4'b1111;
      for (int n = 1; n <= 6; n++) begin
         step();
         chk($sformatf("sim_valid_e%0d", n), {7'd0, a_if.ev_valid}, {7'd0, (n >= 2 && n <= 5)});
         if (n >= 2 && n <= 5)
            chk($sformatf("sim_code_e%0d", n), {6'd0, a_if.ev_code}, 8'(n - 2));
      end

      // auto-repeat on button 2: press, then repeats 8, 12, ... 28 edges after the rise
      do_reset();
      rpt_a = 1'b1;
      sb_q.push_back({2'd2, 1'b0});
      for (int i = 0; i < 6; i++) sb_q.push_back({2'd2, 1'b1});
      for (int n = 1; n <= 45; n++) begin
         db_a = (n <= 30) ? 4'b0100 : 4'b0000;
         step();
         chk($sformatf("rpt_valid_e%0d", n), {7'd0, a_if.ev_valid},
             {7'd0, (n == 2) || (n >= 10 && n <= 30 && ((n - 10) % 4) == 0)});
      end
      rpt_a = 1'b0;

      // fairness and release on a repeat-terminal edge, short hold/repeat instance
      do_reset();
      rpt_b = 1'b1;
      b_if.ev_ready = 1'b1;
      n3 = 0;
      c0 = 0;
      for (int n = 1; n <= 16; n++) begin
         db_b = {(n == 4), 2'b00, (n <= 8)};
         step();
         if (b_if.ev_valid && b_if.ev_code == 2'd3 && n3 == 0) n3 = n;
         if (b_if.ev_valid && b_if.ev_code == 2'd0) c0++;
         if (n >= 9)
            chk($sformatf("fair_idle_e%0d", n), {7'd0, b_if.ev_valid}, 8'd0);
      end
      chk("fair_b3_latency_ok", {7'd0, (n3 >= 5 && n3 <= 6)}, 8'd1);
      chk("fair_b0_events", 8'(c0), 8'd4);
      chk("fair_ovr", {4'd0, ovr_b}, 8'd0);

      chk("sb_drained", 8'(sb_q.size()), 8'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
